// File: rtl/fpu_loader_pkg.sv
// Shared types, defaults and the byte-insert helper for the UART program loader.
package fpu_loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_e;

   localparam int unsigned CLKS_PER_BIT_DEF = 347;
   localparam logic [31:0] END_WORD_DEF     = 32'h0000_0FFF;

   typedef logic [1:0] byte_idx_t;

   // Little-endian placement: byte index 0 lands in bits [7:0].
   function automatic logic [31:0] put_byte(input logic [31:0] word,
                                            input byte_idx_t   idx,
                                            input logic [7:0]  data);
      logic [31:0] w;
      w = word;
      w[{idx, 3'b000} +: 8] = data;
      return w;
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, bit timer, LSB-first shift register.
// Emits a one-cycle byte_valid_o per good frame, frame_err_pulse_o per bad stop bit.
module uart_rx_core
   import fpu_loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       frame_err_pulse_o
);
   localparam int unsigned   TW      = $clog2(CLKS_PER_BIT + 1);
   localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

   logic            sync1_q, sync2_q;
   rx_state_e       state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            valid_q, valid_d;
   logic            ferr_q, ferr_d;
   logic            hold_q, hold_d;

   // State register, synchronizer and receive datapath.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= IDLE;
         timer_q <= {TW{1'b0}};
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         hold_q  <= 1'b0;
      end else begin
         sync1_q <= rx_i;
         sync2_q <= sync1_q;
         state_q <= state_d;
         timer_q <= timer_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         hold_q  <= hold_d;
      end
   end

   // Next-state logic; hold_q marks a bad stop bit waiting for the line to return high.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q + TW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      hold_d  = hold_q;
      case (state_q)
         IDLE: begin
            timer_d = {TW{1'b0}};
            if (!sync2_q) state_d = START;
            else          state_d = IDLE;
         end
         START: begin
            if (timer_q == HALF_M1) begin
               timer_d = {TW{1'b0}};
               bit_d   = 3'd0;
               if (sync2_q) state_d = IDLE;
               else         state_d = DATA;
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            if (timer_q == FULL_M1) begin
               timer_d = {TW{1'b0}};
               shift_d = {sync2_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
               else               state_d = DATA;
            end else begin
               state_d = DATA;
            end
         end
         STOP: begin
            if (hold_q) begin
               timer_d = {TW{1'b0}};
               if (sync2_q) begin
                  hold_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  state_d = STOP;
               end
            end else if (timer_q == FULL_M1) begin
               timer_d = {TW{1'b0}};
               if (sync2_q) begin
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  hold_d  = 1'b1;
                  state_d = STOP;
               end
            end else begin
               state_d = STOP;
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = {TW{1'b0}};
            hold_d  = 1'b0;
         end
      endcase
   end

   assign byte_o            = shift_q;
   assign byte_valid_o      = valid_q;
   assign frame_err_pulse_o = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: assembles little-endian words and writes them to instruction memory.
// Optional partial-word idle timeout is enabled by defining UART_LOADER_TIMEOUT_EN.
module uart_prog_loader
   import fpu_loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int unsigned ADDR_W       = 8,
   parameter logic [31:0] END_WORD     = END_WORD_DEF,
   parameter int unsigned TIMEOUT_CLKS = 16 * 347
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              rx_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic              prog_done_o,
   output logic              frame_err_o,
   output logic              ovf_o,
   output logic              timeout_o
);
   localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

   logic [7:0]        rx_byte_s;
   logic              rx_valid_s, rx_ferr_s, to_hit_s;
   logic [31:0]       word_new_s;
   byte_idx_t         byte_cnt_q, byte_cnt_d;
   logic [31:0]       word_q, word_d, wdata_q, wdata_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d, done_q, done_d, ferr_q, ferr_d, ovf_q, ovf_d;

   uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk_i             (wb_clk_i),
      .rst_i             (wb_rst_i),
      .rx_i              (rx_i),
      .byte_o            (rx_byte_s),
      .byte_valid_o      (rx_valid_s),
      .frame_err_pulse_o (rx_ferr_s)
   );

   assign word_new_s = put_byte(word_q, byte_cnt_q, rx_byte_s);

   // Assembler, address and sticky status registers.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         byte_cnt_q <= 2'd0;
         word_q     <= 32'd0;
         wdata_q    <= 32'd0;
         addr_q     <= {ADDR_W{1'b0}};
         we_q       <= 1'b0;
         done_q     <= 1'b0;
         ferr_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         word_q     <= word_d;
         wdata_q    <= wdata_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         done_q     <= done_d;
         ferr_q     <= ferr_d;
         ovf_q      <= ovf_d;
      end
   end

   // The 4th byte decides write vs. terminator; the strobe appears the following cycle.
   always_comb begin
      byte_cnt_d = byte_cnt_q;
      word_d     = word_q;
      wdata_d    = wdata_q;
      we_d       = 1'b0;
      done_d     = done_q;
      ovf_d      = ovf_q;
      ferr_d     = ferr_q | rx_ferr_s;
      if (we_q && (addr_q != ADDR_MAX)) addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      else                              addr_d = addr_q;
      if (done_q) begin
         byte_cnt_d = byte_cnt_q;
      end else if (rx_valid_s) begin
         word_d     = word_new_s;
         byte_cnt_d = byte_cnt_q + 2'd1;
         if (byte_cnt_q == 2'd3) begin
            if (word_new_s == END_WORD) begin
               done_d = 1'b1;
            end else begin
               we_d    = 1'b1;
               wdata_d = word_new_s;
               if (addr_q == ADDR_MAX) begin
                  done_d = 1'b1;
                  ovf_d  = 1'b1;
               end else begin
                  done_d = done_q;
               end
            end
         end else begin
            we_d = 1'b0;
         end
      end else if (to_hit_s) begin
         byte_cnt_d = 2'd0;
         word_d     = 32'd0;
      end else begin
         byte_cnt_d = byte_cnt_q;
      end
   end

`ifdef UART_LOADER_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CLKS + 1);

   logic [CW-1:0] idle_q;
   logic          to_q;

   assign to_hit_s = !done_q && (byte_cnt_q != 2'd0) && !rx_valid_s
                     && (idle_q == CW'(TIMEOUT_CLKS - 1));

   // Idle counter runs only while a partial word is held.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         idle_q <= {CW{1'b0}};
         to_q   <= 1'b0;
      end else begin
         if (rx_valid_s || (byte_cnt_q == 2'd0) || done_q || to_hit_s) idle_q <= {CW{1'b0}};
         else                                                          idle_q <= idle_q + CW'(1);
         to_q <= to_q | to_hit_s;
      end
   end

   assign timeout_o = to_q;
`else
   logic timeout_cfg_unused;

   assign timeout_cfg_unused = (TIMEOUT_CLKS != 32'd0);
   assign to_hit_s           = 1'b0;
   assign timeout_o          = 1'b0;
`endif

   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign prog_done_o = done_q;
   assign frame_err_o = ferr_q;
   assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Randomized self-checking bench for uart_prog_loader with a word-level reference model.
module tb_uart_prog_loader;
   localparam int          CPB  = 8;
   localparam int          AW   = 4;
   localparam int          TO   = 128;
   localparam logic [31:0] ENDW = 32'h0000_0FFF;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rx  = 1'b1;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          prog_done, frame_err, ovf, timeout;

   uart_prog_loader #(
      .CLKS_PER_BIT (CPB),
      .ADDR_W       (AW),
      .END_WORD     (ENDW),
      .TIMEOUT_CLKS (TO)
   ) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .rx_i        (rx),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .prog_done_o (prog_done),
      .frame_err_o (frame_err),
      .ovf_o       (ovf),
      .timeout_o   (timeout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int          m_cnt;
   logic [31:0] m_word;
   int          m_addr;
   bit          m_done, m_ferr, m_ovf, m_to;
   logic [31:0] exp_data_q[$];
   int          exp_addr_q[$];
   int          we_count;
   logic [31:0] last_data;
   int          last_addr;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_word = 32'd0; m_addr = 0;
      m_done = 0; m_ferr = 0; m_ovf = 0; m_to = 0;
      exp_data_q.delete(); exp_addr_q.delete();
      we_count = 0; last_data = 32'hx; last_addr = -1;
   endtask

   task automatic model_byte(input logic [7:0] b, input bit good);
      if (!good) begin
         m_ferr = 1;
      end else if (!m_done) begin
         m_word[8*m_cnt +: 8] = b;
         m_cnt++;
         if (m_cnt == 4) begin
            m_cnt = 0;
            if (m_word == ENDW) begin
               m_done = 1;
            end else begin
               exp_data_q.push_back(m_word);
               exp_addr_q.push_back(m_addr);
               if (m_addr == (1 << AW) - 1) begin
                  m_done = 1;
                  m_ovf  = 1;
               end else begin
                  m_addr++;
               end
            end
         end
      end
   endtask

   task automatic model_long_idle();
      if (m_cnt != 0 && !m_done) begin
         m_cnt = 0;
         m_to  = 1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit good, input int gap);
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      model_byte(b, good);
      rx = good;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1, gap);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      model_reset();
      rst = 1'b0;
   endtask

   task automatic checkpoint(input string nm);
      repeat (4) @(negedge clk);
      chk({nm, "_pending_writes"}, 32'(exp_data_q.size()), 32'd0);
      chk({nm, "_done"},     32'(prog_done), 32'(m_done));
      chk({nm, "_frame_err"}, 32'(frame_err), 32'(m_ferr));
      chk({nm, "_ovf"},      32'(ovf),       32'(m_ovf));
      chk({nm, "_timeout"},  32'(timeout),   32'(m_to));
      chk({nm, "_addr"},     32'(mem_addr),  32'(m_addr));
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if (w == ENDW) w = w ^ 32'h1;
      return w;
   endfunction

   // Compare process: every write strobe must match the next model-predicted write.
   always @(negedge clk) begin
      if (!rst && mem_we) begin
         we_count++;
         last_data = mem_wdata;
         last_addr = int'(mem_addr);
         if (exp_data_q.size() == 0) begin
            chk("unexpected_write", 32'(mem_we), 32'd0);
         end else begin
            chk("write_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
            chk("write_data", mem_wdata, exp_data_q.pop_front());
         end
      end
   end

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_we",    32'(mem_we),    32'd0);
      chk("rst_addr",  32'(mem_addr),  32'd0);
      chk("rst_wdata", mem_wdata,      32'd0);
      chk("rst_done",  32'(prog_done), 32'd0);
      chk("rst_ferr",  32'(frame_err), 32'd0);
      chk("rst_ovf",   32'(ovf),       32'd0);
      chk("rst_to",    32'(timeout),   32'd0);
      rst = 1'b0;

      // Single word
      send_byte(8'h13, 1'b1, 4);
      send_byte(8'h05, 1'b1, 4);
      send_byte(8'h00, 1'b1, 4);
      send_byte(8'h00, 1'b1, 4);
      checkpoint("single");
      chk("single_count", 32'(we_count), 32'd1);
      chk("single_data",  last_data, 32'h0000_0513);
      chk("single_waddr", 32'(last_addr), 32'd0);
      chk("single_next",  32'(mem_addr), 32'd1);
      chk("single_done",  32'(prog_done), 32'd0);

      // Terminator after three words, then ignored bytes
      do_reset();
      for (int i = 0; i < 3; i++) send_word(rand_word(), 3);
      send_word(ENDW, 3);
      checkpoint("term");
      chk("term_done",  32'(prog_done), 32'd1);
      chk("term_count", 32'(we_count), 32'd3);
      send_byte(8'hAA, 1'b1, 3);
      send_byte(8'hBB, 1'b1, 3);
      send_byte(8'hCC, 1'b1, 3);
      send_byte(8'hDD, 1'b1, 3);
      checkpoint("after_term");
      chk("after_term_count", 32'(we_count), 32'd3);

      // Framing error drops a byte
      do_reset();
      send_byte(8'h11, 1'b1, 4);
      send_byte(8'h22, 1'b0, 4);
      send_byte(8'h33, 1'b1, 4);
      send_byte(8'h44, 1'b1, 4);
      send_byte(8'h55, 1'b1, 4);
      checkpoint("ferr");
      chk("ferr_flag", 32'(frame_err), 32'd1);
      chk("ferr_data", last_data, 32'h5544_3311);
      chk("ferr_waddr", 32'(last_addr), 32'd0);

      // Start-bit glitch
      do_reset();
      @(negedge clk);
      rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      repeat (12) @(negedge clk);
      checkpoint("glitch");
      chk("glitch_count", 32'(we_count), 32'd0);
      send_word(32'hDEAD_BEEF, 4);
      checkpoint("glitch_after");
      chk("glitch_data", last_data, 32'hDEAD_BEEF);

      // Memory full
      do_reset();
      for (int i = 0; i < 16; i++) send_word(rand_word(), 2);
      checkpoint("full");
      chk("full_count", 32'(we_count), 32'd16);
      chk("full_addr",  32'(mem_addr), 32'd15);
      chk("full_ovf",   32'(ovf), 32'd1);
      chk("full_done",  32'(prog_done), 32'd1);

      // Asynchronous reset mid-byte of word 2
      do_reset();
      send_word(rand_word(), 3);
      send_byte(8'h5A, 1'b1, 3);
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB + 5) @(negedge clk);
      rx = 1'b1;
      repeat (CPB - 2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_we",    32'(mem_we),    32'd0);
      chk("arst_addr",  32'(mem_addr),  32'd0);
      chk("arst_wdata", mem_wdata,      32'd0);
      chk("arst_done",  32'(prog_done), 32'd0);
      chk("arst_ferr",  32'(frame_err), 32'd0);
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      send_byte(8'h78, 1'b1, 3);
      send_byte(8'h56, 1'b1, 3);
      send_byte(8'h34, 1'b1, 3);
      send_byte(8'h12, 1'b1, 3);
      checkpoint("arst_after");
      chk("arst_data",  last_data, 32'h1234_5678);
      chk("arst_waddr", 32'(last_addr), 32'd0);

      // Random words with random framing errors and gaps, then terminator
      do_reset();
      for (int w = 0; w < 8; w++) begin
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 7) == 0) send_byte(8'($urandom), 1'b0, $urandom_range(2, 20));
            send_byte(8'($urandom), 1'b1, $urandom_range(2, 20));
         end
      end
      send_word(ENDW, 3);
      checkpoint("random");

`ifdef UART_LOADER_TIMEOUT_EN
      // Partial word timeout
      do_reset();
      send_byte(8'hC3, 1'b1, 3);
      send_byte(8'h3C, 1'b1, 3);
      repeat (130) @(negedge clk);
      model_long_idle();
      checkpoint("timeout");
      chk("timeout_flag", 32'(timeout), 32'd1);
      send_word(32'hCAFE_F00D, 3);
      checkpoint("timeout_after");
      chk("timeout_data",  last_data, 32'hCAFE_F00D);
      chk("timeout_waddr", 32'(last_addr), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Sits in the user project between GPIO pad mprj_io[5] (serial program stream) and the FPU core's instruction memory write port.
- Receives 8N1 UART bytes and assembles them little-endian into 32-bit words.
- Writes each word to consecutive memory addresses.
- Raises prog_done_o (routed to mprj_io[37]) when the terminator word arrives or memory is full; the core starts executing on that signal.

Parameters:
- CLKS_PER_BIT, 347, wb_clk_i cycles per UART bit (40 MHz / 115200).
- ADDR_W, 8, instruction memory word-address width.
- END_WORD, 32'h00000FFF, terminator word; it is not written to memory.
- TIMEOUT_CLKS, 16*347, idle cycles before a partial word is discarded (used only with the optional feature).

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- rx_i  in  1  UART serial input (mprj_io[5]), asynchronous to clock
- mem_we_o  out  1  one-cycle write strobe to instruction memory
- mem_addr_o  out  ADDR_W  word address of the current/next write
- mem_wdata_o  out  32  assembled word
- prog_done_o  out  1  sticky: loading finished
- frame_err_o  out  1  sticky: at least one stop-bit error seen
- ovf_o  out  1  sticky: memory filled before terminator
- timeout_o  out  1  sticky: partial word discarded (0 when feature is compiled out)

Behaviour:
- Reset (async, active-high) clears every output to 0, byte_cnt to 0, and the RX FSM to IDLE. The rx synchronizer resets to 1.
- rx_i passes through a 2-flop synchronizer; all logic uses the synchronized value.
- RX FSM (sub-module):
  - IDLE: a low synchronized rx moves to START and clears the bit-timer.
  - START: at CLKS_PER_BIT/2, re-sample. Low moves to DATA; high returns to IDLE (glitch rejected, no byte).
  - DATA: every CLKS_PER_BIT, sample one bit, LSB first. After 8 bits, move to STOP.
  - STOP: at CLKS_PER_BIT, sample. High gives a 1-cycle byte_valid, then IDLE. Low sets frame_err_o, drops the byte, and waits in STOP until rx is high before returning to IDLE.
- Assembler:
  - On byte_valid, the byte goes to word[8*byte_cnt +: 8] and byte_cnt increments mod 4.
  - On the 4th byte, the action is decided in the next cycle:
    - word == END_WORD: prog_done_o=1, no write.
    - otherwise: mem_we_o=1 for exactly one cycle, with mem_wdata_o=word and mem_addr_o=current address. mem_addr_o increments by 1 the cycle after the strobe.
  - Latency: mem_we_o rises 1 cycle after the byte_valid of byte 3.
- Full memory: a write to address 2^ADDR_W-1 also sets prog_done_o=1 and ovf_o=1. mem_addr_o does not wrap; it holds at 2^ADDR_W-1.
- While prog_done_o=1:
  - all further bytes are ignored: no writes, byte_cnt frozen;
  - the RX FSM keeps running, so frame_err_o can still set.
- Dropped bytes (framing errors) do not advance byte_cnt; the next good byte takes that slot.
- A reset at any point (mid-byte, mid-word, after done) returns everything to the reset state. Loading restarts at address 0.

Optional Feature:
- Macro UART_LOADER_TIMEOUT_EN.
- Defined: an idle counter runs while byte_cnt != 0 and resets on every byte_valid. When it reaches TIMEOUT_CLKS, byte_cnt is set to 0, the partial word is discarded, and timeout_o is set (sticky). No write occurs.
- Undefined: no counter; a partial word is held indefinitely and timeout_o is tied to 0.

Decomposition:
- Package fpu_loader_pkg holds:
  - the RX state enum (IDLE, START, DATA, STOP);
  - the default CLKS_PER_BIT and END_WORD constants;
  - a byte-index type (2-bit).
- One sub-module, uart_rx_core: synchronizer, RX FSM, bit-timer and shift register. It outputs byte_o[7:0], byte_valid_o and frame_err_pulse_o.
- Assembly, addressing, done/overflow and timeout logic stay in uart_prog_loader.

Test Plan (CLKS_PER_BIT=8, ADDR_W=4, TIMEOUT_CLKS=128):
- Bytes 13,05,00,00 → single mem_we_o pulse with addr 0 and wdata 32'h00000513; mem_addr_o=1 afterwards; prog_done_o stays 0.
- Three words, then bytes FF,0F,00,00 → writes at addr 0,1,2; prog_done_o=1; no 4th write; subsequent bytes AA,BB,CC,DD produce no write.
- Byte 2 sent with stop bit 0, then good bytes → frame_err_o=1; the bad byte is dropped; the word is assembled from the next four good bytes and written at the expected address.
- rx low for 2 clocks, then high → no byte_valid, no state change; a following valid byte is received correctly.
- 16 non-terminator words → writes at addr 0..15; after the addr-15 write, prog_done_o=1 and ovf_o=1; mem_addr_o holds at 15.
- Assert wb_rst_i mid-byte of word 2 → all outputs 0 immediately. Then send bytes 78,56,34,12 → write at addr 0 with wdata 32'h12345678.
- With UART_LOADER_TIMEOUT_EN: send 2 bytes, idle 130 clocks → timeout_o=1; the next 4 bytes form a complete word, written at addr 0.
